// File: rtl/freqin_avg.sv
// freqin_avg: power-of-two moving average of the freqin period word, sampled
// once every SAMPLE_DIV clocks, with an optional CLK_FREQ / period divider.
// Build option: define FREQIN_AVG_HZ_EN to include the Hz divider; without it
// out_hz and hz_valid are tied to 0.
module freqin_avg #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned SAMPLE_DIV = 64,
  parameter int unsigned CLK_FREQ   = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_period,
  output logic        out_valid,
  output logic [31:0] out_period,
  output logic [31:0] out_hz,
  output logic        hz_valid
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned         SUM_W     = 32 + DEPTH_LOG2;
  localparam int unsigned         TCK_W     = $clog2(SAMPLE_DIV);
  localparam logic [TCK_W-1:0]    TCK_LAST  = TCK_W'(SAMPLE_DIV - 1);
  localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [TCK_W-1:0]      tck_q, tck_d;
  logic [31:0]           ring_q [DEPTH];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DEPTH_LOG2-1:0] wr_q, wr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  push_q;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_period_q, out_period_d;

  logic                  tick_s;
  logic                  push_s;
  logic                  flush_s;
  logic                  start_s;
  logic [31:0]           avg_s;

  // in_valid low empties the window; a push needs a tick and a non-zero period.
  assign tick_s  = (tck_q == TCK_LAST);
  assign flush_s = ~in_valid;
  assign push_s  = tick_s & in_valid & (in_period != 32'd0);
  assign avg_s   = sum_q[SUM_W-1:DEPTH_LOG2];
  assign start_s = push_q & in_valid & (fill_q == FILL_FULL);

  // Free-running sample tick counter, untouched by flush.
  always_comb begin
    tck_d = tck_q;
    if (tick_s) begin
      tck_d = '0;
    end else begin
      tck_d = tck_q + TCK_W'(1);
    end
  end

  // Running sum, write pointer and fill level of the ring.
  always_comb begin
    sum_d  = sum_q;
    wr_d   = wr_q;
    fill_d = fill_q;
    if (flush_s) begin
      sum_d  = '0;
      wr_d   = '0;
      fill_d = '0;
    end else if (push_s) begin
      // The oldest entry (zero while filling) leaves the sum as the new one enters.
      sum_d = sum_q + SUM_W'(in_period) - SUM_W'(ring_q[wr_q]);
      wr_d  = wr_q + DEPTH_LOG2'(1);
      if (fill_q == FILL_FULL) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + (DEPTH_LOG2 + 1)'(1);
      end
    end else begin
      sum_d = sum_q;
    end
  end

  // Averaged period is published the cycle after a push that leaves the window full.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_period_d = out_period_q;
    if (flush_s) begin
      out_valid_d  = 1'b0;
      out_period_d = 32'd0;
    end else if (start_s) begin
      out_valid_d  = 1'b1;
      out_period_d = avg_s;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Ring storage: cleared on flush, one entry written per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= 32'd0;
    end else if (flush_s) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= 32'd0;
    end else if (push_s) begin
      ring_q[wr_q] <= in_period;
    end
  end

  // Averaging state and period output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_q        <= '0;
      sum_q        <= '0;
      wr_q         <= '0;
      fill_q       <= '0;
      push_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_period_q <= 32'd0;
    end else begin
      tck_q        <= tck_d;
      sum_q        <= sum_d;
      wr_q         <= wr_d;
      fill_q       <= fill_d;
      push_q       <= push_s;
      out_valid_q  <= out_valid_d;
      out_period_q <= out_period_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_period = out_period_q;

`ifdef FREQIN_AVG_HZ_EN
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  itr_q, itr_d;
  logic [31:0] hz_q, hz_d;
  logic        hzv_q, hzv_d;
  logic [32:0] trial_s;
  logic [32:0] diff_s;

  // Restoring divider: one quotient bit per clock, MSB first; a new start restarts it.
  always_comb begin
    state_d = state_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    itr_d   = itr_q;
    hz_d    = hz_q;
    hzv_d   = hzv_q;
    trial_s = {rem_q, quo_q[31]};
    // The remainder stays below the divisor, so bit 32 of the difference is a clean borrow.
    // A zero divisor never borrows and so yields an all-ones quotient.
    diff_s  = trial_s - {1'b0, dvsr_q};
    if (flush_s) begin
      state_d = DIV_IDLE;
      hz_d    = 32'd0;
      hzv_d   = 1'b0;
    end else if (start_s) begin
      state_d = DIV_RUN;
      dvsr_d  = avg_s;
      rem_d   = 32'd0;
      quo_d   = 32'(CLK_FREQ);
      itr_d   = 5'd0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          state_d = DIV_IDLE;
        end
        DIV_RUN: begin
          if (!diff_s[32]) begin
            rem_d = diff_s[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = trial_s[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          if (itr_q == 5'd31) begin
            state_d = DIV_DONE;
          end else begin
            itr_d = itr_q + 5'd1;
          end
        end
        DIV_DONE: begin
          hz_d    = quo_q;
          hzv_d   = 1'b1;
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // Divider state and Hz output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      dvsr_q  <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      itr_q   <= 5'd0;
      hz_q    <= 32'd0;
      hzv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      itr_q   <= itr_d;
      hz_q    <= hz_d;
      hzv_q   <= hzv_d;
    end
  end

  assign out_hz   = hz_q;
  assign hz_valid = hzv_q;
`else
  assign out_hz   = 32'd0;
  assign hz_valid = 1'b0;
`endif

endmodule
